// File: rtl/axi_lite_reg_slave_if.sv
// rtl/axi_lite_reg_slave_if.sv - AXI4-Lite control-port signal bundle with master/slave views
interface axi_lite_reg_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite slave register file with flat register bus and write strobes
module axi_lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_NUM_REGS         = 4
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESETN,
  axi_lite_reg_slave_if.slave                      s_axi,
  output logic [C_S_AXI_DATA_WIDTH*C_NUM_REGS-1:0] slv_regs,
  output logic [C_NUM_REGS-1:0]                    wr_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic          rst_done;
  logic          aw_held;
  logic          w_held;
  logic [IW-1:0] aw_idx;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          bvalid;
  logic [1:0]    bresp;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [DW-1:0] regs [C_NUM_REGS];

  logic          awready;
  logic          wready;
  logic          arready;
  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic [IW-1:0] ar_idx;
  logic          aw_in_range;
  logic          ar_in_range;
  logic [DW-1:0] rd_word;
  logic          unused_bits;

  // A pending B response blocks both write channels so a held write never overtakes it.
  assign awready = rst_done & ~aw_held & ~bvalid;
  assign wready  = rst_done & ~w_held & ~bvalid;
  assign arready = rst_done & ~rvalid;

  assign aw_hs = s_axi.awvalid & awready;
  assign w_hs  = s_axi.wvalid & wready;
  assign ar_hs = s_axi.arvalid & arready;

  assign ar_idx      = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_in_range = 32'(aw_idx) < 32'(C_NUM_REGS);
  assign ar_in_range = 32'(ar_idx) < 32'(C_NUM_REGS);

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.arready = arready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rdata   = rdata;
  assign s_axi.rresp   = rresp;

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (32'(ar_idx) == 32'(i)) rd_word = regs[i];
    end
  end

  always_comb begin
    slv_regs = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      slv_regs[DW*i +: DW] = regs[i];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rst_done <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      wr_pulse <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
    end else begin
      rst_done <= 1'b1;
      wr_pulse <= '0;

      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end

      if (aw_held && w_held) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (32'(aw_idx) == 32'(i)) begin
            wr_pulse[i] <= 1'b1;
            for (int b = 0; b < SW; b++) begin
              if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
            end
          end
        end
      end else if (bvalid && s_axi.bready) begin
        bvalid <= 1'b0;
      end

      // rd_word reflects the registers before any commit on this same edge.
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= ar_in_range ? rd_word : '0;
        rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid && s_axi.rready) begin
        rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb/tb_axi_lite_reg_slave.sv - scoreboard bench driving a 4-register and a 3-register instance in lockstep
module tb_axi_lite_reg_slave;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_reg_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus4 ();
  axi_lite_reg_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus3 ();
  logic [127:0] regs4;
  logic [95:0]  regs3;
  logic [3:0]   pulse4;
  logic [2:0]   pulse3;

  axi_lite_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .C_NUM_REGS(4)) u_dut4 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(bus4), .slv_regs(regs4), .wr_pulse(pulse4));
  axi_lite_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .C_NUM_REGS(3)) u_dut3 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(bus3), .slv_regs(regs3), .wr_pulse(pulse3));

  assign bus3.awaddr  = bus4.awaddr;
  assign bus3.awprot  = bus4.awprot;
  assign bus3.awvalid = bus4.awvalid;
  assign bus3.wdata   = bus4.wdata;
  assign bus3.wstrb   = bus4.wstrb;
  assign bus3.wvalid  = bus4.wvalid;
  assign bus3.bready  = bus4.bready;
  assign bus3.araddr  = bus4.araddr;
  assign bus3.arprot  = bus4.arprot;
  assign bus3.arvalid = bus4.arvalid;
  assign bus3.rready  = bus4.rready;

  int checks = 0;
  int errors = 0;
  int pc4[4] = '{0, 0, 0, 0};
  int pc3[3] = '{0, 0, 0};
  logic [1:0]  bq4[$];
  logic [1:0]  bq3[$];
  logic [33:0] rq4[$];
  logic [33:0] rq3[$];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rd4;
    logic [1:0]  resp4;
    logic [31:0] rd3;
    logic [1:0]  resp3;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: response with nothing pending", name);
  endtask

  // Responses are compared at the handshake, against what was queued when the request went out.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus4.bvalid && bus4.bready) begin
        if (bq4.size() == 0) unexpected("b4_stray"); else chk("b4_bresp", bus4.bresp, bq4.pop_front());
      end
      if (bus3.bvalid && bus3.bready) begin
        if (bq3.size() == 0) unexpected("b3_stray"); else chk("b3_bresp", bus3.bresp, bq3.pop_front());
      end
      if (bus4.rvalid && bus4.rready) begin
        if (rq4.size() == 0) unexpected("r4_stray"); else chk("r4_data_resp", {bus4.rdata, bus4.rresp}, rq4.pop_front());
      end
      if (bus3.rvalid && bus3.rready) begin
        if (rq3.size() == 0) unexpected("r3_stray"); else chk("r3_data_resp", {bus3.rdata, bus3.rresp}, rq3.pop_front());
      end
      for (int i = 0; i < 4; i++) if (pulse4[i]) pc4[i]++;
      for (int i = 0; i < 3; i++) if (pulse3[i]) pc3[i]++;
      if (|pulse4) chk("pulse4_with_bvalid", bus4.bvalid, 1'b1);
    end
  end

  task automatic wait_b();
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = bus4.bvalid && bus4.bready;
      tick();
    end
    chk("b_handshake", got, 1'b1);
  endtask

  task automatic send_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit aw_fire;
    bit w_fire;
    bus4.awaddr = addr; bus4.awvalid = 1'b1;
    bus4.wdata = data; bus4.wstrb = strb; bus4.wvalid = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      @(negedge clk);
      aw_fire = bus4.awvalid && bus4.awready;
      w_fire  = bus4.wvalid && bus4.wready;
      tick();
      if (aw_fire) begin aw_done = 1'b1; bus4.awvalid = 1'b0; end
      if (w_fire) begin w_done = 1'b1; bus4.wvalid = 1'b0; end
    end
    chk("write_accepted", {aw_done, w_done}, 2'b11);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] r4, input logic [1:0] r3);
    bq4.push_back(r4);
    bq3.push_back(r3);
    bus4.bready = 1'b1;
    send_write(addr, data, strb);
    wait_b();
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [33:0] e4, input logic [33:0] e3);
    bit ar_done = 1'b0;
    bit got = 1'b0;
    rq4.push_back(e4);
    rq3.push_back(e3);
    bus4.araddr = addr; bus4.arvalid = 1'b1; bus4.rready = 1'b1;
    for (int n = 0; n < 20 && !ar_done; n++) begin
      @(negedge clk);
      ar_done = bus4.arvalid && bus4.arready;
      tick();
    end
    bus4.arvalid = 1'b0;
    chk("read_accepted", ar_done, 1'b1);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = bus4.rvalid && bus4.rready;
      tick();
    end
    chk("r_handshake", got, 1'b1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {bus4.awready, bus4.wready, bus4.arready, bus4.bvalid, bus4.rvalid,
               bus4.bresp, bus4.rresp, pulse4, pulse3}, '0);
    chk({name, "_data"}, {bus4.rdata, bus3.rdata}, '0);
    chk({name, "_regs4"}, regs4[63:0] | regs4[127:64], '0);
    chk({name, "_regs3"}, {32'h0, regs3[95:64] | regs3[63:32] | regs3[31:0]}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'h0, 32'h0101FFFF, 4'hF, 32'h0101FFFF, OK, 32'h0101FFFF, OK};
    vecs[1] = '{4'h4, 32'hABCD0001, 4'hF, 32'hABCD0001, OK, 32'hABCD0001, OK};
    vecs[2] = '{4'h8, 32'hDEAD0011, 4'hF, 32'hDEAD0011, OK, 32'hDEAD0011, OK};
    vecs[3] = '{4'hC, 32'hBEEF0011, 4'hF, 32'hBEEF0011, OK, 32'h00000000, ERR};
    vecs[4] = '{4'h0, 32'h12345678, 4'h5, 32'h0134FF78, OK, 32'h0134FF78, OK};
    vecs[5] = '{4'h6, 32'hFFFFFFFF, 4'h0, 32'hABCD0001, OK, 32'hABCD0001, OK};
    vecs[6] = '{4'h9, 32'h11223344, 4'hA, 32'h11AD3311, OK, 32'h11AD3311, OK};

    bus4.awaddr = '0; bus4.awprot = 3'b111; bus4.awvalid = 1'b0;
    bus4.wdata = '0; bus4.wstrb = '0; bus4.wvalid = 1'b0; bus4.bready = 1'b0;
    bus4.araddr = '0; bus4.arprot = 3'b111; bus4.arvalid = 1'b0; bus4.rready = 1'b0;

    repeat (3) tick();
    chk_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", {bus4.awready, bus4.wready, bus4.arready}, 3'b000);
    tick();
    chk("ready_after_first_edge", {bus4.awready, bus4.wready, bus4.arready}, 3'b111);

    for (int i = 0; i < 7; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].resp4, vecs[i].resp3);
      axi_read(vecs[i].addr, {vecs[i].rd4, vecs[i].resp4}, {vecs[i].rd3, vecs[i].resp3});
    end
    chk("regs4_after_table", regs4, {32'hBEEF0011, 32'h11AD3311, 32'hABCD0001, 32'h0134FF78});
    chk("regs3_after_table", regs3, {32'h11AD3311, 32'hABCD0001, 32'h0134FF78});

    // W three cycles ahead of AW.
    bus4.bready = 1'b0;
    bq4.push_back(OK); bq3.push_back(OK);
    bus4.wdata = 32'hCAFEF00D; bus4.wstrb = 4'hF; bus4.wvalid = 1'b1;
    chk("wfirst_wready", bus4.wready, 1'b1);
    tick();
    bus4.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wfirst_wready_low", {bus4.wready, bus4.bvalid}, 2'b00);
      tick();
    end
    bus4.awaddr = 4'h4; bus4.awvalid = 1'b1;
    chk("wfirst_awready", bus4.awready, 1'b1);
    tick();
    bus4.awvalid = 1'b0;
    chk("wfirst_latched", {bus4.awready, bus4.wready, bus4.bvalid}, 3'b000);
    tick();
    chk("wfirst_commit", {bus4.bvalid, pulse4}, {1'b1, 4'b0010});
    chk("wfirst_reg1", regs4[63:32], 32'hCAFEF00D);
    bus4.bready = 1'b1;
    wait_b();

    // AW three cycles ahead of W.
    bus4.bready = 1'b0;
    bq4.push_back(OK); bq3.push_back(OK);
    bus4.awaddr = 4'h8; bus4.awvalid = 1'b1;
    chk("awfirst_awready", bus4.awready, 1'b1);
    tick();
    bus4.awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("awfirst_awready_low", {bus4.awready, bus4.bvalid}, 2'b00);
      tick();
    end
    bus4.wdata = 32'h5A5A5A5A; bus4.wstrb = 4'hF; bus4.wvalid = 1'b1;
    chk("awfirst_wready", bus4.wready, 1'b1);
    tick();
    bus4.wvalid = 1'b0;
    chk("awfirst_latched", {bus4.awready, bus4.wready, bus4.bvalid}, 3'b000);
    tick();
    chk("awfirst_commit", {bus4.bvalid, pulse4, pulse3}, {1'b1, 4'b0100, 3'b100});
    bus4.bready = 1'b1;
    wait_b();
    axi_read(4'h4, {32'hCAFEF00D, OK}, {32'hCAFEF00D, OK});
    axi_read(4'h8, {32'h5A5A5A5A, OK}, {32'h5A5A5A5A, OK});

    // Response back-pressure with a second write queued behind it.
    bus4.bready = 1'b0;
    bq4.push_back(OK); bq3.push_back(ERR);
    bq4.push_back(OK); bq3.push_back(OK);
    bus4.awaddr = 4'hC; bus4.wdata = 32'h01020304; bus4.wstrb = 4'hF;
    bus4.awvalid = 1'b1; bus4.wvalid = 1'b1;
    chk("bp_first_ready", {bus4.awready, bus4.wready}, 2'b11);
    tick();
    bus4.awvalid = 1'b0; bus4.wvalid = 1'b0;
    tick();
    chk("bp_first_bvalid", {bus4.bvalid, bus3.bvalid, bus3.bresp}, {2'b11, ERR});
    chk("bp_dut3_no_change", regs3, {32'h5A5A5A5A, 32'hCAFEF00D, 32'h0134FF78});
    bus4.awaddr = 4'h0; bus4.wdata = 32'h55AA55AA; bus4.awvalid = 1'b1; bus4.wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stall", {bus4.bvalid, bus4.bresp, bus4.awready, bus4.wready}, {1'b1, OK, 2'b00});
      tick();
    end
    bus4.bready = 1'b1;
    wait_b();
    send_write(4'h0, 32'h55AA55AA, 4'hF);
    wait_b();
    axi_read(4'hC, {32'h01020304, OK}, {32'h00000000, ERR});
    axi_read(4'h0, {32'h55AA55AA, OK}, {32'h55AA55AA, OK});

    chk("pulse_count4", {pc4[3][7:0], pc4[2][7:0], pc4[1][7:0], pc4[0][7:0]}, 32'h02030303);
    chk("pulse_count3", {pc3[2][7:0], pc3[1][7:0], pc3[0][7:0]}, 24'h030303);

    // Reset with an AW held and a read response stalled.
    bus4.rready = 1'b0;
    bus4.awaddr = 4'h4; bus4.awvalid = 1'b1;
    bus4.araddr = 4'h0; bus4.arvalid = 1'b1;
    tick();
    bus4.awvalid = 1'b0; bus4.arvalid = 1'b0;
    tick();
    chk("pre_reset_state", {bus4.awready, bus4.wready, bus4.rvalid, bus4.bvalid}, 4'b0110);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus4.bready = 1'b1; bus4.rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_quiet", {bus4.bvalid, bus4.rvalid, bus3.bvalid, bus3.rvalid}, 4'b0000);
    end
    axi_write(4'h8, 32'h0F0F0F0F, 4'hF, OK, OK);
    axi_read(4'h8, {32'h0F0F0F0F, OK}, {32'h0F0F0F0F, OK});
    axi_read(4'h4, {32'h00000000, OK}, {32'h00000000, OK});
    chk("regs4_after_reset", regs4, {32'h0, 32'h0F0F0F0F, 32'h0, 32'h0});

    tick();
    chk("queues_drained", {bq4.size(), bq3.size(), rq4.size(), rq3.size()}, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
